// File: rtl/uart_pkg.sv
// Shared receiver state encoding, parity-mode encodings and the parity check helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rxState_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // onesOdd is the XOR over data bits and the received parity bit.
  function automatic logic parityError(input logic onesOdd, input int mode);
    if (mode == PAR_EVEN) return onesOdd;
    if (mode == PAR_ODD)  return ~onesOdd;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; write lands one cycle after wrVld&wrRdy, head visible combinationally.
// Full FIFO deasserts wrRdy unless a pop happens in the same cycle; head reads as zero when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     wrVld,
  output logic                     wrRdy,
  input  logic [WIDTH-1:0]         wrDat,
  output logic                     rdVld,
  input  logic                     rdRdy,
  output logic [WIDTH-1:0]         rdDat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             full;
  logic             wrFire;
  logic             rdFire;

  assign full   = (count == FULL_CNT);
  assign rdVld  = (count != '0);
  assign wrRdy  = ~full | rdRdy;
  assign wrFire = wrVld & wrRdy;
  assign rdFire = rdVld & rdRdy;
  assign rdDat  = rdVld ? mem[rdPtr] : '0;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrFire) wrPtr <= wrPtr + AW'(1);
      if (rdFire) rdPtr <= rdPtr + AW'(1);
      case ({wrFire, rdFire})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrFire) mem[wrPtr] <= wrDat;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampled UART receiver feeding a show-ahead frame FIFO; first frame visible 155 cycles after the start edge.
// The serial line cannot be stalled: a frame completing into a full FIFO is dropped and overrunH latches.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_l,
  input  logic                          uart_REC_dataH,
  input  logic                          rd_enH,
  input  logic                          clr_errH,
  output logic [DATA_BITS-1:0]          rec_dataH,
  output logic                          rec_perrH,
  output logic                          rec_ferrH,
  output logic                          rec_readyH,
  output logic                          overrunH,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_countH
);

  localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = 4;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } rxFrame_t;

  logic [1:0]           syncQ;
  logic                 rxLine;
  rxState_e             state;
  rxState_e             stateNext;
  logic [CNT_W-1:0]     sampleCnt;
  logic [CNT_W-1:0]     cntNext;
  logic [BIT_W-1:0]     bitCnt;
  logic [BIT_W-1:0]     bitNext;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] shiftNext;
  logic                 perrQ;
  logic                 perrNext;
  logic                 ferrQ;
  logic                 ferrNext;
  logic                 ferrNow;
  logic                 pushVld;
  logic                 pushRdy;
  rxFrame_t             pushFrame;
  rxFrame_t             headFrame;
  logic                 headVld;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) syncQ <= 2'b11;
    else            syncQ <= {syncQ[0], uart_REC_dataH};
  end

  assign rxLine = syncQ[1];

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state     <= IDLE;
      sampleCnt <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      perrQ     <= 1'b0;
      ferrQ     <= 1'b0;
    end else begin
      state     <= stateNext;
      sampleCnt <= cntNext;
      bitCnt    <= bitNext;
      shiftReg  <= shiftNext;
      perrQ     <= perrNext;
      ferrQ     <= ferrNext;
    end
  end

  always_comb begin
    stateNext      = state;
    cntNext        = sampleCnt + CNT_W'(1);
    bitNext        = bitCnt;
    shiftNext      = shiftReg;
    perrNext       = perrQ;
    ferrNext       = ferrQ;
    ferrNow        = ferrQ | ~rxLine;
    pushVld        = 1'b0;
    pushFrame.data = shiftReg;
    pushFrame.perr = perrQ;
    pushFrame.ferr = ferrNow;
    case (state)
      IDLE: begin
        cntNext = '0;
        if (!rxLine) begin
          stateNext = START;
          bitNext   = '0;
          perrNext  = 1'b0;
          ferrNext  = 1'b0;
        end
      end
      // Mid-bit recheck of the start bit rejects short glitches.
      START: begin
        if (sampleCnt == HALF_LAST) begin
          cntNext   = '0;
          stateNext = rxLine ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sampleCnt == FULL_LAST) begin
          cntNext   = '0;
          shiftNext = {rxLine, shiftReg[DATA_BITS-1:1]};
          if (bitCnt == DATA_LAST) begin
            bitNext   = '0;
            stateNext = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            bitNext = bitCnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (sampleCnt == FULL_LAST) begin
          cntNext   = '0;
          perrNext  = parityError(^{shiftReg, rxLine}, PARITY_MODE);
          stateNext = STOP;
        end
      end
      STOP: begin
        if (sampleCnt == FULL_LAST) begin
          cntNext  = '0;
          ferrNext = ferrNow;
          if (bitCnt == STOP_LAST) begin
            pushVld   = 1'b1;
            bitNext   = '0;
            stateNext = rxLine ? IDLE : BREAK;
          end else begin
            bitNext = bitCnt + BIT_W'(1);
          end
        end
      end
      // Line held low past the frame: wait for it to return high before hunting again.
      BREAK: begin
        cntNext = '0;
        if (rxLine) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk   (sys_clk),
    .rstN  (sys_rst_l),
    .wrVld (pushVld),
    .wrRdy (pushRdy),
    .wrDat (pushFrame),
    .rdVld (headVld),
    .rdRdy (rd_enH),
    .rdDat (headFrame),
    .count (fifo_countH)
  );

  // A dropped frame beats a same-cycle clear so no overrun is ever lost.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l)              overrunH <= 1'b0;
    else if (pushVld && !pushRdy) overrunH <= 1'b1;
    else if (clr_errH)           overrunH <= 1'b0;
  end

  assign rec_dataH  = headFrame.data;
  assign rec_perrH  = headFrame.perr;
  assign rec_ferrH  = headFrame.ferr;
  assign rec_readyH = headVld;

endmodule
